video_line_scanout: RTL and testbench

- Pixel source stage directly upstream of the VGA timing/output stage.
- Double-buffered 640-entry line buffer of 8-bit palette indices:
  - the renderer fills the back bank;
  - the front bank is scanned out per pixel.
- Each scanned index goes through a 256x12 palette RAM and is delivered as palette_rgb_data with the fixed 2-cycle latency the output stage expects.
- Horizontal scaling uses a fractional step accumulator.

---
 rtl/video_line_scanout.sv | 109 ++++++++++
 tb/tb_video_line_scanout.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_line_scanout.sv
// Pixel source stage: a double-buffered line buffer of palette indices, scanned out through
// a 256x12 palette with a fractional horizontal step and a fixed two-cycle pixel latency.
module video_line_scanout #(
  parameter int unsigned LINE_WIDTH = 640,
  parameter int unsigned FRAC_BITS  = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next_frame,
  input  logic        next_line,
  input  logic        next_pixel,
  input  logic [7:0]  hscale,
  input  logic [7:0]  border_index,
  input  logic        lb_wr_en,
  input  logic [9:0]  lb_wr_addr,
  input  logic [7:0]  lb_wr_data,
  input  logic        pal_wr_en,
  input  logic [7:0]  pal_wr_addr,
  input  logic [11:0] pal_wr_data,
  output logic        render_start,
  output logic        render_bank,
  output logic [11:0] palette_rgb_data
);

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned ACC_W  = ADDR_W + FRAC_BITS;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned PAL_N  = 256;
  localparam int unsigned LB_N   = 2 * LINE_WIDTH;
  localparam int unsigned LB_AW  = ADDR_W + 1;

  logic               r_display_bank;
  logic [ACC_W-1:0]   r_accum;
  logic               r_render_start;
  logic [IDX_W-1:0]   r_lb_mem [LB_N];
  logic [RGB_W-1:0]   r_pal_mem [PAL_N];
  logic [IDX_W-1:0]   r_lb_q;
  logic               r_oob;
  logic               r_s1_vld;
  logic [RGB_W-1:0]   r_pal_q;

  logic [ADDR_W-1:0]  w_src;
  logic               w_oob;
  logic [LB_AW-1:0]   w_lb_rd_addr;
  logic [LB_AW-1:0]   w_lb_wr_addr;
  logic               w_lb_wr_ok;
  logic [SUM_W-1:0]   w_sum;
  logic [ACC_W-1:0]   w_accum_next;
  logic [IDX_W-1:0]   w_index;

  // Both banks live in one array: bank 1 occupies the upper LINE_WIDTH entries.
  function automatic logic [LB_AW-1:0] lb_addr(input logic bank, input logic [ADDR_W-1:0] a);
    return bank ? LB_AW'(LINE_WIDTH) + LB_AW'(a) : LB_AW'(a);
  endfunction

  assign w_src        = r_accum[ACC_W-1 -: ADDR_W];
  assign w_oob        = (w_src >= ADDR_W'(LINE_WIDTH));
  assign w_lb_rd_addr = lb_addr(r_display_bank, w_oob ? '0 : w_src);
  assign w_lb_wr_ok   = lb_wr_en && (lb_wr_addr < ADDR_W'(LINE_WIDTH));
  assign w_lb_wr_addr = lb_addr(~r_display_bank, lb_wr_addr);
  assign w_sum        = {1'b0, r_accum} + SUM_W'(hscale);
  assign w_accum_next = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
  assign w_index      = r_oob ? border_index : r_lb_q;

  // Line buffer: write into the render bank, synchronous read from the display bank.
  always_ff @(posedge clk) begin
    if (w_lb_wr_ok) begin
      r_lb_mem[w_lb_wr_addr] <= lb_wr_data;
    end
    r_lb_q <= r_lb_mem[w_lb_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (pal_wr_en) begin
      r_pal_mem[pal_wr_addr] <= pal_wr_data;
    end
  end

  // Bank control, scan accumulator and the registered pipeline stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_display_bank <= 1'b0;
      r_accum        <= '0;
      r_render_start <= 1'b0;
      r_oob          <= 1'b0;
      r_s1_vld       <= 1'b0;
      r_pal_q        <= '0;
    end else begin
      r_render_start <= next_line;
      if (next_line) begin
        r_display_bank <= next_frame ? 1'b1 : ~r_display_bank;
        r_accum        <= '0;
      end else if (next_pixel) begin
        r_accum <= w_accum_next;
      end
      r_oob    <= w_oob;
      r_s1_vld <= 1'b1;
      // Read-first: a same-cycle palette write is seen from the following cycle.
      r_pal_q  <= r_s1_vld ? r_pal_mem[w_index] : '0;
    end
  end

  assign render_start     = r_render_start;
  assign render_bank      = ~r_display_bank;
  assign palette_rgb_data = r_pal_q;

endmodule

// File: tb/tb_video_line_scanout.sv
// Self-checking bench for video_line_scanout: an arithmetic per-pixel model feeds a
// timed expectation queue that a single compare process checks every cycle.
module tb_video_line_scanout;

  localparam int LW      = 640;
  localparam int ACC_MAX = 131071;

  logic        clk = 1'b0;
  logic        rst;
  logic        next_frame;
  logic        next_line;
  logic        next_pixel;
  logic [7:0]  hscale;
  logic [7:0]  border_index;
  logic        lb_wr_en;
  logic [9:0]  lb_wr_addr;
  logic [7:0]  lb_wr_data;
  logic        pal_wr_en;
  logic [7:0]  pal_wr_addr;
  logic [11:0] pal_wr_data;
  logic        render_start;
  logic        render_bank;
  logic [11:0] palette_rgb_data;

  typedef struct {
    int          due;
    int          x;
    logic [11:0] val;
    bit          lit_en;
    logic [11:0] lit;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  lb_m [2][LW];
  logic [11:0] pal_m [256];
  int          m_disp;
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  int          wr_pattern;
  int          pal_wr_x;
  logic [7:0]  pal_wr_a;
  logic [11:0] pal_wr_d;
  int          rst_x;
  int          lit_n;
  int          lit_x [8];
  logic [11:0] lit_v [8];

  video_line_scanout dut (
    .clk              (clk),
    .rst              (rst),
    .next_frame       (next_frame),
    .next_line        (next_line),
    .next_pixel       (next_pixel),
    .hscale           (hscale),
    .border_index     (border_index),
    .lb_wr_en         (lb_wr_en),
    .lb_wr_addr       (lb_wr_addr),
    .lb_wr_data       (lb_wr_data),
    .pal_wr_en        (pal_wr_en),
    .pal_wr_addr      (pal_wr_addr),
    .pal_wr_data      (pal_wr_data),
    .render_start     (render_start),
    .render_bank      (render_bank),
    .palette_rgb_data (palette_rgb_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int x, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s x=%0d actual=%h required=%h", name, x, act, req);
    end
  endtask

  function automatic logic [11:0] pal_init(input int i);
    logic [7:0] iv;
    iv = 8'(i);
    return {iv[3:0], ~iv[3:0], 4'h5};
  endfunction

  function automatic logic [7:0] pat(input int p, input int x);
    return (p == 1) ? 8'(x) : 8'(x * 3 + 7);
  endfunction

  // Pixel x of a line sits at source position floor(min(x*hscale, max)/128).
  function automatic logic [11:0] model_pix(input int x, input int hs, input logic [7:0] bidx);
    int a;
    int src;
    logic [7:0] idx;
    a = x * hs;
    if (a > ACC_MAX) a = ACC_MAX;
    src = a / 128;
    idx = (src >= LW) ? bidx : lb_m[m_disp][src];
    return pal_m[idx];
  endfunction

  always @(negedge clk) begin : cmp
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      chk("pixel_model", e.x, 32'(palette_rgb_data), 32'(e.val));
      if (e.lit_en) chk("pixel_literal", e.x, 32'(palette_rgb_data), 32'(e.lit));
    end
  end

  task automatic clear_strobes();
    lb_wr_en    = 1'b0;
    lb_wr_addr  = '0;
    lb_wr_data  = '0;
    pal_wr_en   = 1'b0;
    pal_wr_addr = '0;
    pal_wr_data = '0;
  endtask

  task automatic clear_lits();
    lit_n = 0;
  endtask

  task automatic add_lit(input int x, input logic [11:0] v);
    lit_x[lit_n] = x;
    lit_v[lit_n] = v;
    lit_n++;
  endtask

  task automatic push_exp(input int x, input logic [7:0] hs, input logic [7:0] bidx);
    exp_t e;
    e.due    = cyc + 2;
    e.x      = x;
    e.val    = model_pix(x, int'(hs), bidx);
    e.lit_en = 1'b0;
    e.lit    = '0;
    for (int i = 0; i < lit_n; i++) begin
      if (lit_x[i] == x) begin
        e.lit_en = 1'b1;
        e.lit    = lit_v[i];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_rgb", -1, 32'(palette_rgb_data), 32'h0);
    chk("rst_render_bank", -1, 32'(render_bank), 32'd1);
    chk("rst_render_start", -1, 32'(render_start), 32'd0);
    exp_q.delete();
    m_disp = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic scan_line(input logic [7:0] hs, input logic [7:0] bidx, input bit nf);
    int rb;
    @(negedge clk);
    clear_strobes();
    next_line    = 1'b1;
    next_frame   = nf;
    next_pixel   = 1'b1;
    hscale       = hs;
    border_index = bidx;
    m_disp = nf ? 1 : 1 - m_disp;
    rb     = 1 - m_disp;
    for (int x = 0; x < LW; x++) begin
      @(negedge clk);
      next_line  = 1'b0;
      next_frame = 1'b0;
      clear_strobes();
      if (x == 0) begin
        chk("render_start_pulse", x, 32'(render_start), 32'd1);
        chk("render_bank", x, 32'(render_bank), 32'(rb));
      end
      if (x == 1) chk("render_start_drop", x, 32'(render_start), 32'd0);
      if (x == rst_x) begin
        do_reset();
        return;
      end
      if (wr_pattern != 0) begin
        lb_wr_en   = 1'b1;
        lb_wr_addr = 10'(x);
        lb_wr_data = pat(wr_pattern, x);
        lb_m[rb][x] = lb_wr_data;
      end
      if (x == pal_wr_x) begin
        pal_wr_en   = 1'b1;
        pal_wr_addr = pal_wr_a;
        pal_wr_data = pal_wr_d;
        pal_m[pal_wr_a] = pal_wr_d;
      end
      push_exp(x, hs, bidx);
    end
  endtask

  task automatic pulse_nl(input bit nf, input logic exp_rb);
    @(negedge clk);
    clear_strobes();
    next_line  = 1'b1;
    next_frame = nf;
    m_disp = nf ? 1 : 1 - m_disp;
    @(negedge clk);
    next_line  = 1'b0;
    next_frame = 1'b0;
    chk("bank_render_start", -1, 32'(render_start), 32'd1);
    chk("bank_render_bank_model", -1, 32'(render_bank), 32'(1 - m_disp));
    chk("bank_render_bank_literal", -1, 32'(render_bank), 32'(exp_rb));
    @(negedge clk);
    chk("bank_render_start_drop", -1, 32'(render_start), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    next_frame   = 1'b0;
    next_line    = 1'b0;
    next_pixel   = 1'b0;
    hscale       = 8'd128;
    border_index = 8'h33;
    clear_strobes();
    wr_pattern = 0;
    pal_wr_x   = -1;
    pal_wr_a   = '0;
    pal_wr_d   = '0;
    rst_x      = -1;
    lit_n      = 0;
    m_disp     = 0;

    repeat (3) @(negedge clk);
    chk("reset_render_bank", -1, 32'(render_bank), 32'd1);
    chk("reset_render_start", -1, 32'(render_start), 32'd0);
    chk("reset_rgb", -1, 32'(palette_rgb_data), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pal_wr_en   = 1'b1;
      pal_wr_addr = 8'(i);
      pal_wr_data = pal_init(i);
      pal_m[i]    = pal_wr_data;
    end
    for (int x = 0; x < LW; x++) begin
      @(negedge clk);
      clear_strobes();
      lb_wr_en   = 1'b1;
      lb_wr_addr = 10'(x);
      lb_wr_data = pat(1, x);
      lb_m[1][x] = lb_wr_data;
    end

    // 1:1 scan of bank 1 while bank 0 is rendered with a second pattern.
    clear_lits();
    add_lit(10, 12'hA55);
    add_lit(300, 12'hC35);
    add_lit(639, 12'hF05);
    wr_pattern = 2;
    scan_line(8'd128, 8'h33, 1'b1);
    wr_pattern = 0;

    // Out-of-range write into render bank 0 must not land anywhere.
    @(negedge clk);
    clear_strobes();
    lb_wr_en   = 1'b1;
    lb_wr_addr = 10'd700;
    lb_wr_data = 8'hEE;

    clear_lits();
    add_lit(0, 12'h785);
    scan_line(8'd128, 8'h33, 1'b0);

    // 2x zoom of bank 1; bank 0 refilled with the identity pattern.
    clear_lits();
    add_lit(0, 12'h0F5);
    add_lit(1, 12'h0F5);
    add_lit(2, 12'h1E5);
    add_lit(3, 12'h1E5);
    add_lit(120, 12'hC35);
    add_lit(639, 12'hF05);
    wr_pattern = 1;
    scan_line(8'd64, 8'h33, 1'b0);
    wr_pattern = 0;

    // Fast step runs off the end of the line into the border colour.
    clear_lits();
    add_lit(321, 12'hF05);
    add_lit(322, 12'h3C5);
    add_lit(639, 12'h3C5);
    scan_line(8'd255, 8'h33, 1'b0);

    // Palette write to entry 5 while pixel 5 is in its palette-read stage.
    clear_lits();
    add_lit(5, 12'h5A5);
    add_lit(261, 12'h9B1);
    pal_wr_x = 6;
    pal_wr_a = 8'd5;
    pal_wr_d = 12'h9B1;
    scan_line(8'd128, 8'h33, 1'b0);
    pal_wr_x = -1;

    // Zero step with a frame restart while bank 1 is already displayed.
    clear_lits();
    add_lit(0, 12'h0F5);
    add_lit(639, 12'h0F5);
    scan_line(8'd0, 8'h33, 1'b1);

    pulse_nl(1'b0, 1'b1);
    pulse_nl(1'b0, 1'b0);
    pulse_nl(1'b0, 1'b1);
    pulse_nl(1'b1, 1'b0);
    pulse_nl(1'b1, 1'b0);
    pulse_nl(1'b0, 1'b1);
    pulse_nl(1'b1, 1'b0);
    pulse_nl(1'b0, 1'b1);

    // Reset in the middle of a line, then a clean restart on the next line.
    clear_lits();
    rst_x = 300;
    scan_line(8'd128, 8'h33, 1'b0);
    rst_x = -1;

    clear_lits();
    add_lit(0, 12'h0F5);
    add_lit(5, 12'h9B1);
    add_lit(10, 12'hA55);
    scan_line(8'd128, 8'h33, 1'b0);

    repeat (4) @(negedge clk);
    chk("queue_drained", -1, 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
